// File: rtl/gauss_pkg.sv
// gauss_pkg: shared types for the 3x3 Gaussian frame controller.
package gauss_pkg;

   // Pixel coordinate inside a frame (up to 4095).
   typedef logic [11:0] coord_t;

   // Frame sequencer states; encodings are visible on oState.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Turn an integer image dimension into a coordinate value.
   function automatic coord_t to_coord(input int unsigned v);
      return coord_t'(v);
   endfunction

endpackage

// File: rtl/gauss_pos_cnt.sv
// gauss_pos_cnt: raster col/row counter with line wrap and a sticky
// overflow flag for strobes that arrive after the last line of a frame.
module gauss_pos_cnt
   import gauss_pkg::*;
#(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   clr,
   input  logic   adv,
   input  logic   extra,
   output coord_t col,
   output coord_t row,
   output logic   col_last,
   output logic   at_last,
   output logic   ovf
);

   localparam coord_t COL_LAST = to_coord(IMG_W - 1);
   localparam coord_t ROW_LAST = to_coord(IMG_H - 1);

   assign col_last = (col == COL_LAST);
   assign at_last  = col_last && (row == ROW_LAST);

   // Raster position; rests on the final pixel once the frame is complete.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (clr) begin
         col <= '0;
         row <= '0;
      end else if (adv && !at_last) begin
         if (col_last) begin
            col <= '0;
            row <= row + coord_t'(1);
         end else begin
            col <= col + coord_t'(1);
         end
      end
   end

   // Any strobe belonging to a frame already past its last line is excess.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (extra) begin
         ovf <= 1'b1;
      end
   end

endmodule

// File: rtl/gauss_frame_ctrl.sv
// gauss_frame_ctrl: frame sequencer that tells a 3x3 Gaussian filter when
// its window is fully populated and where the window centre sits.
// Build macro GAUSS_FRAME_STATS_EN adds oFrameCnt, a wrapping count of
// completed frames.
module gauss_frame_ctrl
   import gauss_pkg::*;
#(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iEN,
   input  logic        iFVAL,
   input  logic        iDVAL,
   output logic        oWinValid,
   output logic [11:0] oCol,
   output logic [11:0] oRow,
   output logic        oSOF,
   output logic        oEOF,
   output logic        oAbort,
   output logic        oOvf,
   output logic [1:0]  oState
`ifdef GAUSS_FRAME_STATS_EN
   ,
   output logic [15:0] oFrameCnt
`endif
);

   localparam coord_t FIRST_WIN = coord_t'(2);
   localparam coord_t PRIME_ROW = coord_t'(1);

   state_t state;
   coord_t col;
   coord_t row;
   logic   col_last;
   logic   at_last;
   logic   cnt_ovf;
   logic   fval_d;
   logic   tail;

   logic   active;
   logic   fval_rise;
   logic   fval_fall;
   logic   final_px;
   logic   abort;
   logic   start;
   logic   adv;
   logic   extra;
   logic   win_now;

   // Per-cycle decode of frame events from the current state and inputs.
   always_comb begin
      active    = (state == ST_PRIME) || (state == ST_RUN);
      fval_rise = iFVAL && !fval_d;
      fval_fall = !iFVAL && fval_d;
      // The last pixel wins over a simultaneous iFVAL drop.
      final_px  = (state == ST_RUN) && iDVAL && at_last;
      abort     = active && fval_fall && !final_px;
      start     = (state == ST_IDLE) && iEN && fval_rise;
      adv       = active && iDVAL && !abort;
      extra     = tail && iDVAL;
      win_now   = (state == ST_RUN) && adv && (col >= FIRST_WIN);
   end

   gauss_pos_cnt #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) u_pos_cnt (
      .clk      (iCLK),
      .rst_n    (iRST),
      .clr      (start || abort),
      .adv      (adv),
      .extra    (extra),
      .col      (col),
      .row      (row),
      .col_last (col_last),
      .at_last  (at_last),
      .ovf      (cnt_ovf)
   );

   // Frame FSM with registered window/event outputs.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state     <= ST_IDLE;
         // Treat iFVAL as already high so a frame in flight at reset release is skipped.
         fval_d    <= 1'b1;
         tail      <= 1'b0;
         oWinValid <= 1'b0;
         oCol      <= '0;
         oRow      <= '0;
         oSOF      <= 1'b0;
         oEOF      <= 1'b0;
         oAbort    <= 1'b0;
      end else begin
         fval_d    <= iFVAL;
         oWinValid <= win_now;
         oCol      <= win_now ? (col - coord_t'(1)) : '0;
         oRow      <= win_now ? (row - coord_t'(1)) : '0;
         oSOF      <= win_now && (col == FIRST_WIN) && (row == FIRST_WIN);
         oEOF      <= final_px;
         oAbort    <= abort;

         // Tail marks the remainder of a completed frame while iFVAL stays high.
         if (final_px) begin
            tail <= iFVAL;
         end else if (!iFVAL) begin
            tail <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_PRIME;
               end
            end
            ST_PRIME: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else if (adv && col_last && (row == PRIME_ROW)) begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else if (final_px) begin
                  state <= ST_DONE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign oOvf   = cnt_ovf;
   assign oState = state;

`ifdef GAUSS_FRAME_STATS_EN
   // Completed-frame counter, stepped on the same edge that raises oEOF.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         oFrameCnt <= '0;
      end else if (final_px) begin
         oFrameCnt <= oFrameCnt + 16'd1;
      end
   end
`endif

endmodule

// File: doc/gauss_frame_ctrl.md
GAUSS_FRAME_CTRL -- requirements
Module: gauss_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 640, meaning active pixels per line (range 3..4095).
REQ-002 SHALL have parameter IMG_H, default 480, meaning active lines per frame (range 3..4095).
REQ-003 SHALL have port iCLK, input, 1, pixel clock; all logic on its rising edge.
REQ-004 SHALL have port iRST, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port iEN, input, 1, level; frame processing is permitted while high.
REQ-006 SHALL have port iFVAL, input, 1, camera frame valid.
REQ-007 SHALL have port iDVAL, input, 1, pixel strobe, shared with the 3x3 filter line buffers.
REQ-008 SHALL have port oWinValid, output, 1, the filter's 3x3 window is fully populated for the current output pixel.
REQ-009 SHALL have port oCol, output, 12, window-centre column, valid with oWinValid.
REQ-010 SHALL have port oRow, output, 12, window-centre row, valid with oWinValid.
REQ-011 SHALL have port oSOF, output, 1, one-cycle pulse on the first oWinValid of a frame.
REQ-012 SHALL have port oEOF, output, 1, one-cycle pulse on the last oWinValid of a frame.
REQ-013 SHALL have port oAbort, output, 1, one-cycle pulse when a frame ends early.
REQ-014 SHALL have port oOvf, output, 1, sticky flag set by excess pixels or lines.
REQ-015 SHALL have port oState, output, 2, current FSM state encoding.

Function
REQ-016 SHALL implement states IDLE=0, PRIME=1, RUN=2, DONE=3.
REQ-017 SHALL leave IDLE for PRIME on a rising edge of iFVAL while iEN=1; a frame already in progress when iEN rises is skipped.
REQ-018 SHALL keep a column counter col and a row counter row; each advances only on iDVAL=1.
REQ-019 SHALL wrap col from IMG_W-1 to 0 and increment row on that same cycle.
REQ-020 SHALL move PRIME to RUN on the iDVAL that wraps row 1 to row 2 (both line buffers primed).
REQ-021 SHALL, in RUN, register oWinValid=1 one cycle after any iDVAL with col>=2; at other times oWinValid=0.
REQ-022 SHALL drive oCol=col-1 and oRow=row-1 (centre pixel) registered with oWinValid; 1-cycle latency.
REQ-023 SHALL pulse oSOF with the window at centre (1,1), and pulse oEOF with the window at centre (IMG_W-2, IMG_H-2).
REQ-024 SHALL move RUN to DONE after the pixel at col=IMG_W-1, row=IMG_H-1, then DONE to IDLE on the next cycle.
REQ-025 SHALL hold oWinValid=0 and counters frozen in DONE/IDLE; iDVAL there is ignored without error.
REQ-026 SHALL, on iFVAL falling in PRIME or RUN, pulse oAbort, clear counters, go to IDLE; no oEOF.
REQ-027 SHALL, when iFVAL falls on the same cycle as the final pixel, treat the frame as complete (oEOF, no oAbort).
REQ-028 SHALL set oOvf if row would exceed IMG_H-1 in PRIME or RUN; oOvf clears only on reset.
REQ-029 SHALL, on iEN falling mid-frame, finish the current frame and then remain in IDLE.

Reset
REQ-030 SHALL, on iRST=0, asynchronously force state IDLE, col=row=0, and all outputs to 0.
REQ-031 SHALL, on reset deassertion while iFVAL=1, wait for the next iFVAL rising edge.

Configuration
REQ-032 SHALL, with GAUSS_FRAME_STATS_EN defined, add output oFrameCnt[15:0], which increments on each oEOF, wraps at 0xFFFF->0, and resets to 0.
REQ-033 SHALL, without GAUSS_FRAME_STATS_EN, have no oFrameCnt port and no counter logic.

Structure
REQ-034 SHALL place the state enum and the 12-bit coordinate typedef in shared package gauss_pkg.
REQ-035 SHALL instantiate one sub-module, gauss_pos_cnt (col/row counter with wrap and overflow), under the FSM.

Verification
REQ-036 SHALL cover a full frame with IMG_W=8, IMG_H=6 and continuous iDVAL -> 24 oWinValid; oSOF at (1,1); oEOF at (6,4); oState returns to 0.
REQ-037 SHALL cover gapped iDVAL (1 of 3 cycles) -> same 24 windows; coordinates are monotonic; none while iDVAL is low.
REQ-038 SHALL cover iFVAL dropping at row 3, col 2 -> oAbort=1 for one cycle; no oEOF; next frame starts at (1,1).
REQ-039 SHALL cover 7 lines fed with IMG_H=6 -> oOvf=1 and remains set after a subsequent good frame.
REQ-040 SHALL cover iRST asserted mid-RUN -> all outputs 0 immediately; no windows until a new iFVAL rising edge.
REQ-041 SHALL cover three frames with GAUSS_FRAME_STATS_EN defined -> oFrameCnt=3; with one aborted frame -> 2.
